// File: rtl/crc32_pkg.sv
// ---------------------------------------------------------------------------
// crc32_pkg
// Shared types and constants for the reflected bit-serial CRC-32 engine.
//   state_e          : controller states IDLE / RUN / DONE
//   CRC32_*          : standard Ethernet/zlib polynomial, init and xor-out
//   STEP_COUNT       : RUN cycles per 32-bit word
//   BITS_PER_STEP    : message bits consumed per RUN cycle
// Optional build macro: CRC32_BYTEWISE_EN (8 bits per cycle, 4 RUN cycles).
// ---------------------------------------------------------------------------
package crc32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] CRC32_POLY_DEFAULT = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT         = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT       = 32'hFFFFFFFF;

`ifdef CRC32_BYTEWISE_EN
    localparam int STEP_COUNT    = 4;
    localparam int BITS_PER_STEP = 8;
`else
    localparam int STEP_COUNT    = 32;
    localparam int BITS_PER_STEP = 1;
`endif

    // Value of the 6-bit step counter during the final RUN cycle.
    localparam logic [5:0] LAST_COUNT = 6'(STEP_COUNT - 1);

endpackage

// File: rtl/crc32_step.sv
// ---------------------------------------------------------------------------
// crc32_step
// One combinational step of a reflected (LSB-first) CRC shift register.
//   crc_i   [31:0] : current CRC register value
//   data_i         : next message bit
//   poly_i  [31:0] : reflected polynomial
//   crc_o   [31:0] : CRC after absorbing data_i
// ---------------------------------------------------------------------------
module crc32_step (
    input  logic [31:0] crc_i,
    input  logic        data_i,
    input  logic [31:0] poly_i,
    output logic [31:0] crc_o
);

    logic fb;

    always_comb begin
        fb    = crc_i[0] ^ data_i;
        crc_o = (crc_i >> 1) ^ (fb ? poly_i : 32'h0);
    end

endmodule

// File: rtl/crc32.sv
// ---------------------------------------------------------------------------
// crc32
// Reflected CRC-32 of one 32-bit word (4 bytes, LSB byte first) with a
// run-time programmable polynomial. Level-controlled accelerator slave.
//   clk_i              : clock, rising edge
//   rst_i              : synchronous active-high reset
//   message_i   [31:0] : word to checksum, sampled at start
//   compute_i   [31:0] : bit 0 = start/enable level, other bits ignored
//   polynomial_i[31:0] : reflected polynomial, sampled at start
//   message_o   [31:0] : registered CRC result, held until next completion
// Optional build macro: CRC32_BYTEWISE_EN (8 chained steps per cycle).
// ---------------------------------------------------------------------------
module crc32
    import crc32_pkg::*;
#(
    parameter logic [31:0] INIT_VAL = CRC32_INIT,
    parameter logic [31:0] XOROUT   = CRC32_XOROUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] message_i,
    input  logic [31:0] compute_i,
    input  logic [31:0] polynomial_i,
    output logic [31:0] message_o
);

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] data_q, data_d;
    logic [31:0] poly_q, poly_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] message_q, message_d;

    // Only bit 0 of compute_i carries meaning.
    logic compute_unused;
    assign compute_unused = ^compute_i[31:1];

    // Chain of single-bit steps; chain[BITS_PER_STEP] is the CRC after
    // this cycle's bits have been absorbed (one step in the serial build).
    logic [31:0] chain [0:BITS_PER_STEP];
    assign chain[0] = crc_q;

    generate
        for (genvar gi = 0; gi < BITS_PER_STEP; gi++) begin : g_step
            crc32_step u_step (
                .crc_i  (chain[gi]),
                .data_i (data_q[gi]),
                .poly_i (poly_q),
                .crc_o  (chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        data_d    = data_q;
        poly_d    = poly_q;
        count_d   = count_q;
        message_d = message_q;
        case (state_q)
            IDLE: begin
                if (compute_i[0]) begin
                    data_d  = message_i;
                    poly_d  = polynomial_i;
                    crc_d   = INIT_VAL;
                    count_d = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                crc_d   = chain[BITS_PER_STEP];
                data_d  = data_q >> BITS_PER_STEP;
                count_d = count_q + 6'd1;
                if (count_q == LAST_COUNT) begin
                    message_d = chain[BITS_PER_STEP] ^ XOROUT;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // Requires compute_i[0] to drop before a new request.
                if (!compute_i[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            crc_q     <= 32'h0;
            data_q    <= 32'h0;
            poly_q    <= 32'h0;
            count_q   <= 6'd0;
            message_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            data_q    <= data_d;
            poly_q    <= poly_d;
            count_q   <= count_d;
            message_q <= message_d;
        end
    end

    assign message_o = message_q;

endmodule

// File: tb/tb_crc32.sv
module tb_crc32;

`ifdef CRC32_BYTEWISE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 32;
`endif
    localparam logic [31:0] POLY = 32'hEDB88320;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] message_i;
    logic [31:0] compute_i;
    logic [31:0] polynomial_i;
    logic [31:0] message_o;

    int tests_run = 0;
    int tests_failed = 0;

    crc32 dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .message_i    (message_i),
        .compute_i    (compute_i),
        .polynomial_i (polynomial_i),
        .message_o    (message_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] msg;
        logic [31:0] poly;
        logic [31:0] exp;
    } vec_t;

    // Byte-at-a-time zlib-style CRC: xor in a whole byte, then 8 reductions.
    function automatic logic [31:0] ref_crc(input logic [31:0] msg, input logic [31:0] poly);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            c = c ^ {24'h0, msg[8*i +: 8]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end else begin
            $display("ok   %s: %08h", name, got);
        end
    endtask

    // Pulse a request, verify message_o holds until edge N+LAT, then the result.
    task automatic run_req(input string name, input logic [31:0] msg,
                           input logic [31:0] poly, input logic [31:0] exp);
        logic [31:0] prev;
        prev         = message_o;
        message_i    = msg;
        polynomial_i = poly;
        compute_i    = 32'h1;
        tick();
        compute_i    = 32'h0;
        repeat (LAT - 1) tick();
        check({name, "_hold"}, message_o, prev);
        tick();
        check(name, message_o, exp);
        tick();
    endtask

    vec_t vecs [8];

    initial begin
        logic [31:0] m, p;
        int rst_at;

        vecs[0] = '{32'h00000000, POLY, 32'h2144DF1C};
        vecs[1] = '{32'hFFFFFFFF, POLY, 32'hFFFFFFFF};
        vecs[2] = '{32'hBABECAFE, 32'h0, 32'hFFFFFFFF};
        vecs[3] = '{32'h34333231, POLY, ref_crc(32'h34333231, POLY)};
        vecs[4] = '{32'hBABECAFE, POLY, ref_crc(32'hBABECAFE, POLY)};
        vecs[5] = '{32'h00000001, 32'h82F63B78, ref_crc(32'h00000001, 32'h82F63B78)};
        vecs[6] = '{32'h80000000, POLY, ref_crc(32'h80000000, POLY)};
        vecs[7] = '{32'h12345678, 32'hFFFFFFFF, ref_crc(32'h12345678, 32'hFFFFFFFF)};

        // Reset with compute asserted, then release with compute low.
        rst_i = 1'b1; compute_i = 32'hFFFFFFFF; message_i = 32'hDEADBEEF; polynomial_i = POLY;
        repeat (5) tick();
        check("reset_out", message_o, 32'h0);
        compute_i = 32'h0;
        rst_i = 1'b0;
        repeat (LAT + 3) tick();
        check("idle_after_reset", message_o, 32'h0);

        // Table vectors.
        for (int i = 0; i < 8; i++)
            run_req($sformatf("vec%0d", i), vecs[i].msg, vecs[i].poly, vecs[i].exp);

        // Upper compute bits alone must not start anything.
        compute_i = 32'hFFFFFFFE; message_i = 32'h0;
        repeat (LAT + 3) tick();
        check("upper_bits_ignored", message_o, vecs[7].exp);
        compute_i = 32'h0;
        tick();

        // Inputs changed during RUN have no effect.
        message_i = 32'h0; polynomial_i = POLY; compute_i = 32'h1;
        tick();
        compute_i = 32'h0;
        tick();
        message_i = 32'hBABECAFE; polynomial_i = 32'h0;
        repeat (LAT - 1) tick();
        check("midrun_change", message_o, 32'h2144DF1C);
        tick();

        // Reset in the middle of a computation.
        rst_at = (LAT > 10) ? 10 : 2;
        message_i = 32'hBABECAFE; polynomial_i = POLY; compute_i = 32'h1;
        tick();
        compute_i = 32'h0;
        repeat (rst_at - 1) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrun_reset", message_o, 32'h0);
        repeat (LAT + 2) tick();
        check("midrun_reset_idle", message_o, 32'h0);
        run_req("after_reset", 32'hBABECAFE, POLY, ref_crc(32'hBABECAFE, POLY));

        // Held compute never retriggers.
        message_i = 32'hFFFFFFFF; polynomial_i = POLY; compute_i = 32'h1;
        repeat (LAT + 1) tick();
        check("held_result", message_o, 32'hFFFFFFFF);
        message_i = 32'h0;
        repeat (100) tick();
        check("no_retrigger", message_o, 32'hFFFFFFFF);
        compute_i = 32'h0;
        tick();
        compute_i = 32'h1;
        repeat (LAT + 1) tick();
        check("retrigger_new", message_o, 32'h2144DF1C);
        compute_i = 32'h0;
        tick();

        // Randomized words and polynomials against the byte-wise model.
        for (int i = 0; i < 20; i++) begin
            m = $urandom;
            p = (i % 2 == 0) ? POLY : $urandom;
            run_req($sformatf("rand%0d", i), m, p, ref_crc(m, p));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/crc32.md
Name: crc32

Overview:
- Bit-serial, reflected (LSB-first) CRC-32 engine with a run-time programmable polynomial.
- Computes the CRC of one 32-bit message word per request. The word is consumed as 4 bytes, least significant byte first, matching the standard Ethernet/zlib CRC-32 when polynomial_i = 0xEDB88320.
- Sits as a memory/register-mapped accelerator slave; all control is level-based, with no bus handshake.

Parameters:
- INIT_VAL, 32'hFFFFFFFF, CRC register value loaded at start of each computation.
- XOROUT, 32'hFFFFFFFF, value XORed into the final CRC before it is presented on message_o.

Ports:
- clk_i  in  1  single clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- message_i  in  32  data word to checksum; sampled only at start.
- compute_i  in  32  start/enable request; only bit 0 is meaningful, bits 31:1 are ignored.
- polynomial_i  in  32  reflected polynomial; sampled only at start.
- message_o  out  32  registered CRC result.

Behaviour:
- Reset (rst_i=1 at a rising edge): state=IDLE, crc=0, data=0, poly=0, count=0, message_o=0. Reset overrides everything, including an in-progress RUN; a partial result is never output.
- IDLE: when compute_i[0]=1, latch data=message_i, poly=polynomial_i, crc=INIT_VAL, count=0, and go to RUN.
- RUN: one bit per cycle.
  - fb = crc[0] ^ data[0].
  - crc = (crc>>1) ^ (fb ? poly : 0).
  - data = data>>1; count++.
  - On the 32nd step, register message_o = next_crc ^ XOROUT and go to DONE.
- DONE: message_o is held. Return to IDLE when compute_i[0]=0. Holding compute_i[0]=1 never retriggers; a new request needs compute_i[0] to drop and rise again.
- Latency: request sampled at edge N; message_o valid after edge N+32 (32 shift cycles, the last one also writes message_o).
- message_o keeps the previous result during RUN and only changes at completion.
- Changes to message_i or polynomial_i during RUN or DONE have no effect on the current result.
- Dropping compute_i[0] during RUN does not abort; the computation completes, and DONE then falls straight back to IDLE.
- Counter is 6 bits wide. No wrap-around states exist beyond 32 steps.
- polynomial_i=0 is legal: the result is INIT_VAL shifted per the algorithm, with no error flagging.

Optional Feature:
- Macro CRC32_BYTEWISE_EN.
- When defined: RUN processes 8 bits per cycle (eight chained 1-bit steps combinationally) for 4 cycles total. Result valid after edge N+4. message_o values are identical to the bit-serial build.
- When undefined: bit-serial 32-cycle operation as above.

Decomposition:
- Package crc32_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - constants CRC32_POLY_DEFAULT=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_XOROUT=32'hFFFFFFFF.
  - STEP_COUNT (32, or 4 with CRC32_BYTEWISE_EN).
- One natural combinational sub-module, crc32_step: inputs crc, data bit, poly; output next crc. It is instantiated once, or eight times in a chain under CRC32_BYTEWISE_EN.

Test Plan:
- Reset: rst_i=1 with compute_i=1 for several cycles -> message_o=0 and the FSM stays IDLE; release with compute_i=0 -> message_o stays 0.
- Zero word: poly=0xEDB88320, message_i=0x00000000, pulse compute_i[0] -> message_o=0x2144DF1C exactly 32 cycles later (4 cycles with CRC32_BYTEWISE_EN).
- All ones: message_i=0xFFFFFFFF, same poly -> message_o=0xFFFFFFFF; message_o is unchanged from the prior result until completion.
- Mid-run input change: start with message_i=0x00000000, then change message_i to 0xBABECAFE and polynomial_i to 0 during RUN -> result still 0x2144DF1C.
- Reset mid-operation: assert rst_i at step 10 of a 0xBABECAFE computation -> message_o=0 and IDLE. A new request then produces the same result as an uninterrupted run, compared against a reference model.
- Retrigger rule: hold compute_i[0]=1 past completion for 100 cycles -> single computation, no restart. Drop compute_i[0], change message_i to 0, raise compute_i[0] -> 0x2144DF1C.
